// File: rtl/integrity_checker.sv
// rtl/integrity_checker.sv - scoreboard read-side compare, match/error statistics, first-error capture
// Defining CHK_MASK_EN adds cmp_mask; zero mask bits are don't-care in the compare.
module integrity_checker #(
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 64,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                  out_clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  dut_valid,
  input  logic [DATA_WIDTH-1:0] dut_data,
  input  logic                  sb_empty,
  input  logic [DATA_WIDTH-1:0] sb_data,
`ifdef CHK_MASK_EN
  input  logic [DATA_WIDTH-1:0] cmp_mask,
`endif
  output logic                  sb_rd,
  output logic                  match,
  output logic                  mismatch,
  output logic                  underflow,
  output logic                  timeout,
  output logic                  error,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [DATA_WIDTH-1:0] err_exp,
  output logic [DATA_WIDTH-1:0] err_got
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HALT} state_t;

  // Counter holds 0..TIMEOUT-1; the pulse fires on the idle cycle that would reach TIMEOUT.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                state_q, state_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  match_q, match_d;
  logic                  mismatch_q, mismatch_d;
  logic                  underflow_q, underflow_d;
  logic                  timeout_q, timeout_d;
  logic                  error_q, error_d;
  logic [CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;
  logic [DATA_WIDTH-1:0] err_got_q, err_got_d;

  logic running, data_eq, idle;
  logic match_ev, mismatch_ev, underflow_ev, timeout_ev, any_err;

  assign running = (state_q != ST_HALT);
  assign sb_rd   = rstn & dut_valid & ~sb_empty & running;

`ifdef CHK_MASK_EN
  assign data_eq = (((sb_data ^ dut_data) & cmp_mask) == '0);
`else
  assign data_eq = (sb_data == dut_data);
`endif

  assign match_ev     = sb_rd & data_eq;
  assign mismatch_ev  = sb_rd & ~data_eq;
  assign underflow_ev = dut_valid & sb_empty & running;
  assign idle         = ~sb_empty & ~dut_valid & running;
  assign timeout_ev   = (TIMEOUT != 0) && idle && (tcnt_q == T_LAST);
  assign any_err      = mismatch_ev | underflow_ev | timeout_ev;

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    match_d     = 1'b0;
    mismatch_d  = 1'b0;
    underflow_d = 1'b0;
    timeout_d   = 1'b0;
    error_d     = error_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    if (clr) begin
      // A beat popped in the clr cycle is intentionally dropped from the statistics.
      state_d     = ST_IDLE;
      tcnt_d      = '0;
      error_d     = 1'b0;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      err_exp_d   = '0;
      err_got_d   = '0;
    end else if (running) begin
      if (any_err && (STOP_ON_ERR != 0)) begin
        state_d = ST_HALT;
      end else begin
        state_d = sb_empty ? ST_IDLE : ST_ACTIVE;
      end
      tcnt_d      = ((TIMEOUT != 0) && idle && !timeout_ev) ? tcnt_q + TW'(1) : '0;
      match_d     = match_ev;
      mismatch_d  = mismatch_ev;
      underflow_d = underflow_ev;
      timeout_d   = timeout_ev;
      error_d     = error_q | any_err;
      if (match_ev && (match_cnt_q != '1)) begin
        match_cnt_d = match_cnt_q + CNT_WIDTH'(1);
      end
      if (any_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
      if (!error_q && mismatch_ev) begin
        err_exp_d = sb_data;
        err_got_d = dut_data;
      end else if (!error_q && underflow_ev) begin
        err_exp_d = '0;
        err_got_d = dut_data;
      end
    end
  end

  always_ff @(posedge out_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
      timeout_q   <= 1'b0;
      error_q     <= 1'b0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      match_q     <= match_d;
      mismatch_q  <= mismatch_d;
      underflow_q <= underflow_d;
      timeout_q   <= timeout_d;
      error_q     <= error_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign underflow = underflow_q;
  assign timeout   = timeout_q;
  assign error     = error_q;
  assign halted    = (state_q == ST_HALT);
  assign match_cnt = match_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

endmodule

// File: tb/tb_integrity_checker.sv
// tb/tb_integrity_checker.sv - directed self-checking bench for integrity_checker
// u_a: halting, no timeout, 16-bit counters; u_b: free-running, TIMEOUT=4, 2-bit counters.
module tb_integrity_checker;

  logic       out_clk = 1'b0;
  logic       rstn, clr, dut_valid, sb_empty;
  logic [7:0] dut_data, sb_data;
`ifdef CHK_MASK_EN
  logic [7:0] cmp_mask;
`endif

  logic        a_sb_rd, a_match, a_mismatch, a_underflow, a_timeout, a_error, a_halted;
  logic [15:0] a_match_cnt, a_err_cnt;
  logic [7:0]  a_err_exp, a_err_got;
  logic        b_sb_rd, b_match, b_mismatch, b_underflow, b_timeout, b_error, b_halted;
  logic [1:0]  b_match_cnt, b_err_cnt;
  logic [7:0]  b_err_exp, b_err_got;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 out_clk = ~out_clk;

  integrity_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(0), .STOP_ON_ERR(1)) u_a (
    .out_clk(out_clk), .rstn(rstn), .clr(clr), .dut_valid(dut_valid), .dut_data(dut_data),
    .sb_empty(sb_empty), .sb_data(sb_data),
`ifdef CHK_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .sb_rd(a_sb_rd), .match(a_match), .mismatch(a_mismatch), .underflow(a_underflow),
    .timeout(a_timeout), .error(a_error), .halted(a_halted), .match_cnt(a_match_cnt),
    .err_cnt(a_err_cnt), .err_exp(a_err_exp), .err_got(a_err_got)
  );

  integrity_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2), .TIMEOUT(4), .STOP_ON_ERR(0)) u_b (
    .out_clk(out_clk), .rstn(rstn), .clr(clr), .dut_valid(dut_valid), .dut_data(dut_data),
    .sb_empty(sb_empty), .sb_data(sb_data),
`ifdef CHK_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .sb_rd(b_sb_rd), .match(b_match), .mismatch(b_mismatch), .underflow(b_underflow),
    .timeout(b_timeout), .error(b_error), .halted(b_halted), .match_cnt(b_match_cnt),
    .err_cnt(b_err_cnt), .err_exp(b_err_exp), .err_got(b_err_got)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [7:0] sd, input logic [7:0] dd);
    dut_valid = v;
    sb_empty  = e;
    sb_data   = sd;
    dut_data  = dd;
  endtask

  task automatic pulse_clr();
    @(negedge out_clk);
    clr = 1'b1;
    @(negedge out_clk);
    clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    clr  = 1'b0;
`ifdef CHK_MASK_EN
    cmp_mask = 8'hFF;
`endif
    drive(1'b1, 1'b0, 8'hA5, 8'hA5);
    repeat (3) @(negedge out_clk);
    check("rst_sb_rd", 32'(a_sb_rd), 0);
    check("rst_match_cnt", 32'(a_match_cnt), 0);
    check("rst_error", 32'(a_error), 0);
    check("rst_halted", 32'(a_halted), 0);
    check("rst_pulses", 32'({a_match, a_mismatch, a_underflow, a_timeout}), 0);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    @(negedge out_clk);
    rstn = 1'b1;

    // Three back-to-back matching beats.
    for (int i = 0; i < 3; i++) begin
      @(negedge out_clk);
      if (i > 0) check("t1_match_pulse", 32'(a_match), 1);
      drive(1'b1, 1'b0, 8'hA5, 8'hA5);
      #1 check("t1_sb_rd", 32'(a_sb_rd), 1);
    end
    @(negedge out_clk);
    check("t1_match_last", 32'(a_match), 1);
    check("t1_match_cnt", 32'(a_match_cnt), 3);
    check("t1_b_match_cnt", 32'(b_match_cnt), 3);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    @(negedge out_clk);
    check("t1_match_end", 32'(a_match), 0);

    // Two more matches: 2-bit counter must stay saturated.
    drive(1'b1, 1'b0, 8'h5A, 8'h5A);
    repeat (2) @(negedge out_clk);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    @(negedge out_clk);
    check("t5_a_match_cnt", 32'(a_match_cnt), 5);
    check("t5_b_match_cnt_sat", 32'(b_match_cnt), 3);

    // Mismatch halts u_a but not u_b.
    drive(1'b1, 1'b0, 8'h3C, 8'h3D);
    #1 check("t2_sb_rd", 32'(a_sb_rd), 1);
    @(negedge out_clk);
    check("t2_mismatch", 32'(a_mismatch), 1);
    check("t2_err_exp", 32'(a_err_exp), 32'h3C);
    check("t2_err_got", 32'(a_err_got), 32'h3D);
    check("t2_halted", 32'(a_halted), 1);
    check("t2_error", 32'(a_error), 1);
    check("t2_err_cnt", 32'(a_err_cnt), 1);
    check("t2_b_mismatch", 32'(b_mismatch), 1);
    check("t2_b_halted", 32'(b_halted), 0);
    drive(1'b1, 1'b0, 8'h3C, 8'h3C);
    #1 check("t2_halt_sb_rd", 32'(a_sb_rd), 0);
    check("t2_b_sb_rd", 32'(b_sb_rd), 1);
    @(negedge out_clk);
    check("t2_halt_no_match", 32'({a_match, a_mismatch}), 0);
    check("t2_halt_cnt_frozen", 32'(a_match_cnt), 5);
    check("t2_b_match", 32'(b_match), 1);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    pulse_clr();
    check("t2_clr_halted", 32'(a_halted), 0);
    check("t2_clr_match_cnt", 32'(a_match_cnt), 0);
    check("t2_clr_err_cnt", 32'(a_err_cnt), 0);
    check("t2_clr_error", 32'(a_error), 0);
    check("t2_clr_err_exp", 32'(a_err_exp), 0);

    // clr wins over a same-cycle beat: popped but not counted.
    clr = 1'b1;
    drive(1'b1, 1'b0, 8'hA5, 8'hA5);
    #1 check("clr_beat_sb_rd", 32'(a_sb_rd), 1);
    @(negedge out_clk);
    clr = 1'b0;
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    check("clr_beat_match", 32'(a_match), 0);
    check("clr_beat_match_cnt", 32'(a_match_cnt), 0);

    // Underflow, then no further pulses while halted.
    @(negedge out_clk);
    drive(1'b1, 1'b1, 8'h00, 8'h11);
    #1 check("t3_sb_rd", 32'(a_sb_rd), 0);
    @(negedge out_clk);
    check("t3_underflow", 32'(a_underflow), 1);
    check("t3_err_got", 32'(a_err_got), 32'h11);
    check("t3_err_exp", 32'(a_err_exp), 0);
    check("t3_err_cnt", 32'(a_err_cnt), 1);
    check("t3_halted", 32'(a_halted), 1);
    check("t3_b_underflow", 32'(b_underflow), 1);
    @(negedge out_clk);
    check("t3_halt_no_underflow", 32'(a_underflow), 0);
    check("t3_halt_err_cnt", 32'(a_err_cnt), 1);
    check("t3_b_err_cnt", 32'(b_err_cnt), 2);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    pulse_clr();

    // Idle with scoreboard non-empty: timeout every 4 cycles on u_b only.
    @(negedge out_clk);
    drive(1'b0, 1'b0, 8'h77, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      @(negedge out_clk);
      check("t4_b_timeout", 32'(b_timeout), ((i == 4) || (i == 8)) ? 1 : 0);
      check("t4_a_timeout", 32'(a_timeout), 0);
    end
    check("t4_b_err_cnt", 32'(b_err_cnt), 2);
    check("t4_b_halted", 32'(b_halted), 0);
    check("t4_a_err_cnt", 32'(a_err_cnt), 0);
    drive(1'b0, 1'b1, 8'h00, 8'h00);

    // Asynchronous reset mid-stream.
    @(negedge out_clk);
    drive(1'b1, 1'b0, 8'hA5, 8'hA5);
    @(negedge out_clk);
    check("t5_pre_rst_match", 32'(a_match), 1);
    #2 rstn = 1'b0;
    #1 check("t5_rst_match_cnt", 32'(a_match_cnt), 0);
    check("t5_rst_match", 32'(a_match), 0);
    check("t5_rst_sb_rd", 32'(a_sb_rd), 0);
    check("t5_rst_b_err_cnt", 32'(b_err_cnt), 0);
    @(negedge out_clk);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    rstn = 1'b1;

`ifdef CHK_MASK_EN
    @(negedge out_clk);
    cmp_mask = 8'hF0;
    drive(1'b1, 1'b0, 8'hA1, 8'hA7);
    @(negedge out_clk);
    check("t6_mask_match", 32'(a_match), 1);
    cmp_mask = 8'hFF;
    @(negedge out_clk);
    check("t6_full_mismatch", 32'(a_mismatch), 1);
    check("t6_err_got", 32'(a_err_got), 32'hA7);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
`endif

    @(negedge out_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
